// File: rtl/arr_kernel_host.sv
// Host-side loader/starter for an HLS kernel with an array control port.
// Optional ARR_KERNEL_CYCLE_COUNT_EN adds res_cycles (START..w_enable cycle count).
module arr_kernel_host #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 27,
  parameter int unsigned RES_W   = 64,
  parameter int unsigned MAX_LEN = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              controlArr,
  output logic              controlArrWEnable_a,
  output logic [ADDR_W-1:0] controlArrAddr_a,
  output logic [DATA_W-1:0] controlArrWData_a,
  output logic              r_enable,
  input  logic              w_enable,
  input  logic [RES_W-1:0]  result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic [ADDR_W:0]   res_len,
`ifdef ARR_KERNEL_CYCLE_COUNT_EN
  output logic [31:0]       res_cycles,
`endif
  output logic              res_trunc
);

  typedef enum logic [2:0] {StLoad, StFill, StStart, StWait, StResult} state_e;

  localparam logic [ADDR_W:0] LastIdx = (ADDR_W+1)'(MAX_LEN - 1);

  state_e              state_q;
  logic [ADDR_W:0]     cnt_q;
  logic                ctrl_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                ren_q;
  logic                res_valid_q;
  logic [RES_W-1:0]    res_data_q;
  logic [ADDR_W:0]     res_len_q;
  logic                trunc_q;
`ifdef ARR_KERNEL_CYCLE_COUNT_EN
  logic [31:0]         cyc_q;
  logic [31:0]         res_cycles_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StLoad;
      cnt_q       <= '0;
      ctrl_q      <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ren_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_len_q   <= '0;
      trunc_q     <= 1'b0;
`ifdef ARR_KERNEL_CYCLE_COUNT_EN
      cyc_q        <= '0;
      res_cycles_q <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        StLoad: begin
          if (in_valid) begin
            we_q    <= 1'b1;
            addr_q  <= cnt_q[ADDR_W-1:0];
            wdata_q <= in_data;
            cnt_q   <= cnt_q + 1'b1;
            if (in_last || cnt_q == LastIdx) begin
              res_len_q <= cnt_q + 1'b1;
              // Without in_last this branch is only reachable at the final index.
              trunc_q   <= !in_last;
              state_q   <= (cnt_q == LastIdx) ? StStart : StFill;
            end
          end
        end
        StFill: begin
          we_q    <= 1'b1;
          addr_q  <= cnt_q[ADDR_W-1:0];
          wdata_q <= '0;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LastIdx) state_q <= StStart;
        end
        StStart: begin
          // Last array write is on the bus this cycle; hand over on the next.
          ctrl_q  <= 1'b0;
          ren_q   <= 1'b1;
          state_q <= StWait;
`ifdef ARR_KERNEL_CYCLE_COUNT_EN
          cyc_q   <= 32'd1;
`endif
        end
        StWait: begin
          ren_q <= 1'b0;
          if (w_enable) begin
            res_data_q  <= result;
            ctrl_q      <= 1'b1;
            res_valid_q <= 1'b1;
            state_q     <= StResult;
`ifdef ARR_KERNEL_CYCLE_COUNT_EN
            res_cycles_q <= cyc_q;
          end else if (cyc_q != '1) begin
            cyc_q <= cyc_q + 32'd1;
`endif
          end
        end
        StResult: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            cnt_q       <= '0;
            trunc_q     <= 1'b0;
            state_q     <= StLoad;
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  assign in_ready            = (state_q == StLoad);
  assign controlArr          = ctrl_q;
  assign controlArrWEnable_a = we_q;
  assign controlArrAddr_a    = addr_q;
  assign controlArrWData_a   = wdata_q;
  assign r_enable            = ren_q;
  assign res_valid           = res_valid_q;
  assign res_data            = res_data_q;
  assign res_len             = res_len_q;
  assign res_trunc           = trunc_q;
`ifdef ARR_KERNEL_CYCLE_COUNT_EN
  assign res_cycles          = res_cycles_q;
`endif

endmodule

// File: tb/tb_arr_kernel_host.sv
// Scoreboard bench for arr_kernel_host: array writes and job results checked against queues.
module tb_arr_kernel_host;

  localparam int unsigned AddrW  = 10;
  localparam int unsigned DataW  = 27;
  localparam int unsigned ResW   = 64;
  localparam int unsigned MaxLen = 1000;

  typedef struct packed {
    logic [ResW-1:0] data;
    logic [AddrW:0]  len;
    logic            trunc;
  } res_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DataW-1:0]  in_data;
  logic              in_last;
  logic              controlArr;
  logic              controlArrWEnable_a;
  logic [AddrW-1:0]  controlArrAddr_a;
  logic [DataW-1:0]  controlArrWData_a;
  logic              r_enable;
  logic              w_enable;
  logic [ResW-1:0]   result;
  logic              res_valid;
  logic              res_ready;
  logic [ResW-1:0]   res_data;
  logic [AddrW:0]    res_len;
  logic              res_trunc;
`ifdef ARR_KERNEL_CYCLE_COUNT_EN
  logic [31:0]       res_cycles;
`endif

  res_t                     exp_res_q[$];
  logic [AddrW+DataW-1:0]   exp_wr_q[$];
  logic signed [DataW-1:0]  mem  [MaxLen];
  logic signed [DataW-1:0]  samp [MaxLen];
  int n_checks = 0;
  int n_errors = 0;
  int r_pulses = 0;

  always #5 clk = ~clk;

  arr_kernel_host dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_data             (in_data),
    .in_last             (in_last),
    .controlArr          (controlArr),
    .controlArrWEnable_a (controlArrWEnable_a),
    .controlArrAddr_a    (controlArrAddr_a),
    .controlArrWData_a   (controlArrWData_a),
    .r_enable            (r_enable),
    .w_enable            (w_enable),
    .result              (result),
    .res_valid           (res_valid),
    .res_ready           (res_ready),
    .res_data            (res_data),
    .res_len             (res_len),
`ifdef ARR_KERNEL_CYCLE_COUNT_EN
    .res_cycles          (res_cycles),
`endif
    .res_trunc           (res_trunc)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Array write monitor: every write must match the next expected one, with host ownership.
  always @(negedge clk) begin
    if (r_enable) r_pulses++;
    if (controlArrWEnable_a) begin
      logic [AddrW+DataW-1:0] exp_wr;
      check_eq("wr_owner", 64'(controlArr), 64'(1));
      if (exp_wr_q.size() == 0) begin
        check_eq("wr_extra", 64'(exp_wr_q.size()), 64'(1));
      end else begin
        exp_wr = exp_wr_q.pop_front();
        check_eq("wr", 64'({controlArrAddr_a, controlArrWData_a}), 64'(exp_wr));
      end
      if (int'(controlArrAddr_a) < MaxLen) mem[controlArrAddr_a] = controlArrWData_a;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int n, input bit use_last, input int lat, input int hold,
                         input bit spur, input bit abort);
    longint acc;
    longint kres;
    int     r0;
    int     k;
    res_t   e;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      acc += longint'(samp[i]) * longint'(samp[i]);
      exp_wr_q.push_back({AddrW'(i), samp[i]});
    end
    for (int i = n; i < MaxLen; i++) exp_wr_q.push_back({AddrW'(i), DataW'(0)});
    e.data  = acc;
    e.len   = (AddrW+1)'(n);
    e.trunc = !use_last && (n == MaxLen);
    exp_res_q.push_back(e);
    r0 = r_pulses;

    for (int i = 0; i < n; i++) begin
      if (i % 3 == 1) begin
        in_valid = 1'b0;
        step();
      end
      in_valid = 1'b1;
      in_data  = samp[i];
      in_last  = use_last && (i == n - 1);
      if (spur && i == 1) w_enable = 1'b1;
      step();
      w_enable = 1'b0;
      if (spur && i == 1) check_eq("spur_load_valid", 64'(res_valid), 64'(0));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;

    if (spur) begin
      step();
      w_enable = 1'b1;
      step();
      w_enable = 1'b0;
      check_eq("spur_fill_valid", 64'(res_valid), 64'(0));
      check_eq("spur_fill_ctrl", 64'(controlArr), 64'(1));
    end

    k = 0;
    while (!r_enable && k < 3000) begin
      if (k < 2) check_eq("pre_start_ctrl", 64'(controlArr), 64'(1));
      step();
      k++;
    end
    check_eq("r_enable_seen", 64'(r_enable), 64'(1));
    check_eq("start_ctrl", 64'(controlArr), 64'(0));
    check_eq("start_we", 64'(controlArrWEnable_a), 64'(0));

    if (abort) begin
      repeat (2) step();
      rst_n = 1'b0;
      #1;
      check_eq("abort_ctrl", 64'(controlArr), 64'(1));
      check_eq("abort_ren", 64'(r_enable), 64'(0));
      check_eq("abort_valid", 64'(res_valid), 64'(0));
      check_eq("abort_wr_left", 64'(exp_wr_q.size()), 64'(0));
      void'(exp_res_q.pop_back());
      step();
      rst_n = 1'b1;
      step();
      check_eq("abort_in_ready", 64'(in_ready), 64'(1));
      return;
    end

    kres = 0;
    for (int i = 0; i < MaxLen; i++) kres += longint'(mem[i]) * longint'(mem[i]);
    repeat (lat - 1) step();
    w_enable = 1'b1;
    result   = kres;
    step();
    w_enable = 1'b0;
    result   = '0;
    check_eq("res_valid_up", 64'(res_valid), 64'(1));
    check_eq("res_ctrl", 64'(controlArr), 64'(1));

    for (int h = 0; h < hold; h++) begin
      res_ready = 1'b0;
      step();
      check_eq("hold_valid", 64'(res_valid), 64'(1));
      check_eq("hold_data", res_data, e.data);
      check_eq("hold_in_ready", 64'(in_ready), 64'(0));
    end

    res_ready = 1'b1;
    if (res_valid && exp_res_q.size() != 0) begin
      e = exp_res_q.pop_front();
      check_eq("res_data", res_data, e.data);
      check_eq("res_len", 64'(res_len), 64'(e.len));
      check_eq("res_trunc", 64'(res_trunc), 64'(e.trunc));
`ifdef ARR_KERNEL_CYCLE_COUNT_EN
      check_eq("res_cycles", 64'(res_cycles), 64'(lat));
`endif
    end else begin
      check_eq("res_handshake", 64'(res_valid), 64'(1));
    end
    step();
    res_ready = 1'b0;
    check_eq("post_valid", 64'(res_valid), 64'(0));
    check_eq("post_in_ready", 64'(in_ready), 64'(1));
    check_eq("post_trunc", 64'(res_trunc), 64'(0));
    check_eq("ren_pulses", 64'(r_pulses - r0), 64'(1));
    check_eq("wr_left", 64'(exp_wr_q.size()), 64'(0));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    w_enable  = 1'b0;
    result    = '0;
    res_ready = 1'b0;
    for (int i = 0; i < MaxLen; i++) mem[i] = '0;
    repeat (3) step();
    check_eq("rst_ctrl", 64'(controlArr), 64'(1));
    check_eq("rst_ren", 64'(r_enable), 64'(0));
    check_eq("rst_we", 64'(controlArrWEnable_a), 64'(0));
    check_eq("rst_addr", 64'(controlArrAddr_a), 64'(0));
    check_eq("rst_wdata", 64'(controlArrWData_a), 64'(0));
    check_eq("rst_valid", 64'(res_valid), 64'(0));
    check_eq("rst_data", res_data, 64'(0));
    check_eq("rst_len", 64'(res_len), 64'(0));
    check_eq("rst_trunc", 64'(res_trunc), 64'(0));
    rst_n = 1'b1;
    step();
    check_eq("rst_in_ready", 64'(in_ready), 64'(1));

    // Short job with zero fill: 1 + 4 + 9.
    samp[0] = 27'sd1;
    samp[1] = -27'sd2;
    samp[2] = 27'sd3;
    run_job(3, 1'b1, 5, 0, 1'b0, 1'b0);

    // Full-length job without in_last, most-negative samples.
    for (int i = 0; i < MaxLen; i++) samp[i] = {1'b1, 26'b0};
    run_job(MaxLen, 1'b0, 4, 0, 1'b0, 1'b0);

    // Result back-pressure for 20 cycles.
    for (int i = 0; i < 5; i++) samp[i] = DataW'($urandom_range(0, 32'h7ff_ffff));
    run_job(5, 1'b1, 3, 20, 1'b0, 1'b0);

    // Spurious w_enable during LOAD and FILL.
    samp[0] = 27'sd100;
    samp[1] = -27'sd7;
    samp[2] = 27'sd0;
    samp[3] = 27'sd65535;
    run_job(4, 1'b1, 6, 0, 1'b1, 1'b0);

    // Reset while waiting for the kernel, then a fresh job: 16 + 25.
    samp[0] = 27'sd9;
    samp[1] = 27'sd8;
    samp[2] = 27'sd7;
    run_job(3, 1'b1, 5, 0, 1'b0, 1'b1);
    samp[0] = 27'sd4;
    samp[1] = 27'sd5;
    run_job(2, 1'b1, 7, 2, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
